// File: rtl/alu_writeback_queue.sv
// alu_writeback_queue: condition-gated FIFO between ALU result and register-file write port.
// Latency: a stored result is visible on out_* the cycle after its accept edge (0 with WB_BYPASS_EN on an empty queue).
// Backpressure: in_ready drops when DEPTH entries are held; out_* holds steady while out_ready is low.
//
// Optional feature macro: WB_BYPASS_EN (empty-queue combinational pass-through of a passing result).
// Ports:
//   Clock, Reset (async, active-low)
//   in_valid/in_ready/in_data/in_flags{Z,C,N,O}/in_dest/in_cond : ALU result side
//   out_valid/out_ready/out_data/out_dest                       : register-file write side
//   count (occupancy), drop_count (saturating count of condition-failed results)
module alu_writeback_queue #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4,
  parameter int DEST_W     = 3
) (
  input  logic                    Clock,
  input  logic                    Reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_WIDTH-1:0]   in_data,
  input  logic [3:0]              in_flags,
  input  logic [DEST_W-1:0]       in_dest,
  input  logic [3:0]              in_cond,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_WIDTH-1:0]   out_data,
  output logic [DEST_W-1:0]       out_dest,
  output logic [$clog2(DEPTH):0]  count,
  output logic [7:0]              drop_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [DATA_WIDTH-1:0] data_mem [DEPTH];
  logic [DEST_W-1:0]     dest_mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic                  ready_en;
  logic                  cond_pass;
  logic                  accept;
  logic                  stored_vld;
  logic                  push;
  logic                  pop;
  logic                  bypass;
  logic                  flag_z, flag_c, flag_n, flag_o;

  assign {flag_z, flag_c, flag_n, flag_o} = in_flags;

  always_comb begin
    cond_pass = 1'b0;
    case (in_cond)
      4'd0:  cond_pass = 1'b1;
      4'd1:  cond_pass = flag_z;
      4'd2:  cond_pass = !flag_z;
      4'd3:  cond_pass = flag_c;
      4'd4:  cond_pass = !flag_c;
      4'd5:  cond_pass = flag_n;
      4'd6:  cond_pass = !flag_n;
      4'd7:  cond_pass = flag_o;
      4'd8:  cond_pass = !flag_o;
      4'd9:  cond_pass = flag_c && !flag_z;
      4'd10: cond_pass = !flag_c || flag_z;
      4'd11: cond_pass = (flag_n == flag_o);
      4'd12: cond_pass = (flag_n != flag_o);
      4'd13: cond_pass = !flag_z && (flag_n == flag_o);
      4'd14: cond_pass = flag_z || (flag_n != flag_o);
      default: cond_pass = 1'b0;
    endcase
  end

  // ready_en keeps in_ready low through reset and rises on the first edge after release.
  assign in_ready   = ready_en && (count < FULL_CNT);
  assign accept     = in_valid && in_ready;
  assign stored_vld = (count != '0);
  assign pop        = stored_vld && out_ready;

`ifdef WB_BYPASS_EN
  // Empty queue and a willing consumer: hand the result straight through, never stored.
  assign bypass    = accept && cond_pass && !stored_vld && out_ready;
  assign out_valid = stored_vld || bypass;
  assign out_data  = bypass ? in_data : data_mem[rd_ptr];
  assign out_dest  = bypass ? in_dest : dest_mem[rd_ptr];
`else
  assign bypass    = 1'b0;
  assign out_valid = stored_vld;
  assign out_data  = data_mem[rd_ptr];
  assign out_dest  = dest_mem[rd_ptr];
`endif

  assign push = accept && cond_pass && !bypass;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      ready_en   <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      drop_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        data_mem[i] <= '0;
        dest_mem[i] <= '0;
      end
    end else begin
      ready_en <= 1'b1;
      if (push) begin
        data_mem[wr_ptr] <= in_data;
        dest_mem[wr_ptr] <= in_dest;
        wr_ptr           <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (accept && !cond_pass && (drop_count != 8'hFF)) begin
        drop_count <= drop_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_alu_writeback_queue.sv
module tb_alu_writeback_queue;

  localparam int DW = 32;
  localparam int DEPTH = 4;
  localparam int DEST_W = 3;

  logic              Clock = 1'b0;
  logic              Reset = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DW-1:0]     in_data = '0;
  logic [3:0]        in_flags = '0;
  logic [DEST_W-1:0] in_dest = '0;
  logic [3:0]        in_cond = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [DW-1:0]     out_data;
  logic [DEST_W-1:0] out_dest;
  logic [2:0]        count;
  logic [7:0]        drop_count;

  alu_writeback_queue #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .DEST_W(DEST_W)) dut (
    .Clock(Clock), .Reset(Reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_flags(in_flags),
    .in_dest(in_dest), .in_cond(in_cond),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_dest(out_dest),
    .count(count), .drop_count(drop_count)
  );

  always #5 Clock = ~Clock;

  typedef struct packed {
    logic [DW-1:0]     d;
    logic [DEST_W-1:0] r;
  } ent_t;

  ent_t sb[$];
  int   mdrop = 0;
  bit   minit = 0;
  int   total = 0;
  int   bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t", tag, got, want, $time);
    end
  endtask

  // Flags {Z,C,N,O}; odd codes test a base predicate, the following even code its negation.
  function automatic bit cond_model(input logic [3:0] f, input logic [3:0] c);
    bit z, cf, n, o, base;
    int g;
    z = f[3]; cf = f[2]; n = f[1]; o = f[0];
    if (c == 4'd0)  return 1'b1;
    if (c == 4'd15) return 1'b0;
    g = (int'(c) + 1) / 2;
    case (g)
      1: base = z;
      2: base = cf;
      3: base = n;
      4: base = o;
      5: base = cf & ~z;
      6: base = (n == o);
      default: base = ~z & (n == o);
    endcase
    return c[0] ? base : ~base;
  endfunction

  // Check DUT against the scoreboard on the falling edge, then advance the model across the rising edge.
  task automatic cycle();
    bit pass, acc, byp, exp_rdy;
    @(negedge Clock);
    pass    = cond_model(in_flags, in_cond);
    exp_rdy = minit && (sb.size() < DEPTH);
    acc     = in_valid && exp_rdy;
    byp     = 1'b0;
`ifdef WB_BYPASS_EN
    byp = acc && pass && out_ready && (sb.size() == 0);
`endif
    chk("in_ready", {31'b0, in_ready}, {31'b0, exp_rdy});
    chk("count", {29'b0, count}, sb.size());
    chk("drop_count", {24'b0, drop_count}, mdrop);
    if (byp) begin
      chk("byp_valid", {31'b0, out_valid}, 32'd1);
      chk("byp_data", out_data, in_data);
      chk("byp_dest", {29'b0, out_dest}, {29'b0, in_dest});
    end else begin
      chk("out_valid", {31'b0, out_valid}, (sb.size() != 0) ? 32'd1 : 32'd0);
      if (sb.size() != 0) begin
        chk("out_data", out_data, sb[0].d);
        chk("out_dest", {29'b0, out_dest}, {29'b0, sb[0].r});
      end
    end
    if (sb.size() != 0 && out_ready) void'(sb.pop_front());
    if (acc && pass && !byp) sb.push_back('{d: in_data, r: in_dest});
    if (acc && !pass && mdrop < 255) mdrop++;
    @(posedge Clock);
    if (Reset) minit = 1'b1;
    #1;
  endtask

  task automatic push(input logic [31:0] d, input logic [2:0] r, input logic [3:0] c, input logic [3:0] f);
    in_valid = 1'b1; in_data = d; in_dest = r; in_cond = c; in_flags = f;
    cycle();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 20 && sb.size() != 0; i++) cycle();
    chk("drained_sb", sb.size(), 0);
    chk("drained_cnt", {29'b0, count}, 0);
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst_count", {29'b0, count}, 0);
    chk("rst_valid", {31'b0, out_valid}, 0);
    chk("rst_in_ready", {31'b0, in_ready}, 0);
    chk("rst_data", out_data, 0);
    chk("rst_dest", {29'b0, out_dest}, 0);
    chk("rst_drop", {24'b0, drop_count}, 0);
    @(posedge Clock); #1;
    Reset = 1'b1;
    cycle();
    cycle();

    // Single push, visible next cycle
    out_ready = 1'b0;
    push(32'hAA, 3'd2, 4'd0, 4'b0000);
    cycle();
    chk("first_data", out_data, 32'hAA);
    chk("first_dest", {29'b0, out_dest}, 2);
    drain();

    // Fill, refused fifth push, ordered drain
    out_ready = 1'b0;
    for (int i = 1; i <= 4; i++) push(i, 3'(i), 4'd0, 4'b0000);
    chk("full_count", {29'b0, count}, 4);
    push(32'h5, 3'd5, 4'd0, 4'b0000);
    drain();

    // Condition gating
    out_ready = 1'b0;
    push(32'h44, 3'd1, 4'd1, 4'b0000);
    push(32'h55, 3'd3, 4'd1, 4'b1000);
    cycle();
    chk("eq_data", out_data, 32'h55);
    drain();

    // Saturating drop counter
    out_ready = 1'b0;
    for (int i = 0; i < 300; i++) push(32'(i), 3'd0, 4'd15, 4'(i));
    chk("sat_drop", {24'b0, drop_count}, 255);

    // Full plus simultaneous push/pop
    for (int i = 0; i < 4; i++) push(32'h90 + i, 3'(i), 4'd0, 4'b0000);
    out_ready = 1'b1;
    push(32'h99, 3'd7, 4'd0, 4'b0000);
    chk("full_pp_count", {29'b0, count}, 3);
    push(32'h9A, 3'd6, 4'd0, 4'b0000);
    chk("pp_count", {29'b0, count}, 3);
    drain();

    // Random mix of all condition codes and backpressure
    for (int i = 0; i < 200; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_data   = $urandom;
      in_dest   = 3'($urandom_range(0, 7));
      in_cond   = 4'($urandom_range(0, 15));
      in_flags  = 4'($urandom_range(0, 15));
      out_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end
    drain();

    // Asynchronous reset with entries queued
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) push(32'hC0 + i, 3'(i), 4'd0, 4'b0000);
    #3;
    Reset = 1'b0;
    #1;
    chk("arst_count", {29'b0, count}, 0);
    chk("arst_valid", {31'b0, out_valid}, 0);
    chk("arst_in_ready", {31'b0, in_ready}, 0);
    chk("arst_drop", {24'b0, drop_count}, 0);
    chk("arst_data", out_data, 0);
    sb.delete();
    mdrop = 0;
    minit = 1'b0;
    cycle();
    Reset = 1'b1;
    cycle();
    cycle();

`ifdef WB_BYPASS_EN
    out_ready = 1'b1;
    in_valid = 1'b1; in_data = 32'h77; in_dest = 3'd4; in_cond = 4'd0; in_flags = 4'b0000;
    #1;
    chk("byp_now_valid", {31'b0, out_valid}, 1);
    chk("byp_now_data", out_data, 32'h77);
    cycle();
    in_valid = 1'b0;
    chk("byp_count", {29'b0, count}, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_writeback_queue.md
Name: alu_writeback_queue

Overview:
- Stage directly downstream of the ALU: captures each ALU result with its {Z,C,N,O} flags and destination register index.
- Gates each result by a condition code evaluated on the captured flags; results that fail are dropped.
- Surviving results are buffered in a small FIFO and drained to the register-file write port over a valid/ready handshake.
- Decouples ALU issue from register-file write availability.

Parameters:
- DATA_WIDTH, 32, width of ALU result.
- DEPTH, 4, FIFO entries (power of two, >=2).
- DEST_W, 3, width of destination register index.

Ports:
- Clock  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  ALU result presented.
- in_ready  out  1  queue can accept this cycle.
- in_data  in  DATA_WIDTH  ALU result (ALUOut).
- in_flags  in  4  flags {Z,C,N,O} belonging to in_data.
- in_dest  in  DEST_W  destination register index.
- in_cond  in  4  condition code gating the write.
- out_valid  out  1  head entry valid.
- out_ready  in  1  register file accepts the write.
- out_data  out  DATA_WIDTH  head result.
- out_dest  out  DEST_W  head destination index.
- count  out  $clog2(DEPTH)+1  current occupancy.
- drop_count  out  8  results discarded by failed conditions, saturating.

Behaviour:
- Reset (Reset=0, asynchronous): the following all clear to 0.
  - read pointer, write pointer, count, drop_count, every storage entry.
  - out_valid=0, out_data=0, out_dest=0.
  - in_ready=0 while Reset is low; in_ready=1 from the first cycle after release.
- Reset mid-operation discards all queued entries; no partial write is ever presented.
- Handshake:
  - Accept occurs when in_valid & in_ready at a rising edge.
  - Pop occurs when out_valid & out_ready at a rising edge.
- in_ready = (count < DEPTH). It depends only on registered state; there is no same-cycle pass-through when full.
- Condition evaluation is combinational on in_flags and in_cond:
  - 0 AL: always.
  - 1 EQ: Z. 2 NE: !Z.
  - 3 CS: C. 4 CC: !C.
  - 5 MI: N. 6 PL: !N.
  - 7 VS: O. 8 VC: !O.
  - 9 HI: C&!Z. 10 LS: !C|Z.
  - 11 GE: N==O. 12 LT: N!=O.
  - 13 GT: !Z&(N==O). 14 LE: Z|(N!=O).
  - 15 NV: never.
- Accept with condition true: write {in_data, in_dest} at the write pointer, advance the write pointer, count+1.
- Accept with condition false: nothing is stored and the pointers are unchanged. drop_count increments, saturating at 255.
- Pointers wrap modulo DEPTH.
- out_valid = (count != 0). out_data and out_dest always show the head entry. Head contents are stable while out_valid & !out_ready.
- Simultaneous push (condition true) and pop: count is unchanged and both pointers advance. This is legal at any occupancy, including count==DEPTH-1.
- Empty queue with out_ready=1: no pop; count stays 0.
- Latency: a stored result appears on out_* in the cycle after its accept edge. Minimum latency is 1 cycle.
- Ordering is strict FIFO. Dropped results never reorder survivors.

Optional Feature:
- Macro WB_BYPASS_EN.
- When defined:
  - If count==0, in_valid=1, condition true and out_ready=1, the input drives out_* combinationally that cycle.
  - out_valid=1 in that cycle, and the entry is consumed without being stored. Pointers and count are unchanged.
  - in_ready is unaffected.
- When undefined: no combinational path from in_* to out_*, and minimum latency is 1 cycle.

Test Plan:
- Reset release, then push data=0x0000_00AA, dest=2, cond=AL, flags=0000 with out_ready=0 -> next cycle out_valid=1, out_data=0xAA, out_dest=2, count=1.
- Push 4 entries (0x1,0x2,0x3,0x4), cond=AL, out_ready=0 -> count=4, in_ready=0; a fifth push is not accepted; then out_ready=1 drains 0x1..0x4 in order over 4 cycles.
- Push cond=EQ with flags Z=0, then cond=EQ with Z=1 (data 0x55) -> drop_count=1, only 0x55 queued.
- 300 consecutive pushes with cond=NV -> drop_count=255, count=0, out_valid never asserts.
- Queue full, then push and pop in the same cycle -> in_ready=0 so no push occurs; one pop leaves count=3. Next cycle, push plus pop -> count stays 3 and order is preserved.
- Assert Reset low mid-stream with count=3 -> out_valid=0 and count=0 immediately (asynchronous); with WB_BYPASS_EN, an empty queue plus out_ready=1 and a push of 0x77 shows out_data=0x77 the same cycle and count stays 0.
